datapath_counter: RTL and testbench

Datapath responder for the bit-counting control FSM. It accepts an operand over a valid/ready handshake and issues a one-cycle start pulse to the controller's `init`. It then executes the controller's `out_rst`/`add`/`sft`/`done` strobes, returns the `z`/`a0` status bits, and publishes the final ones-count with a one-cycle valid pulse.

---
 rtl/counter_pkg.sv | 23 ++
 rtl/shift_reg_lsb.sv | 31 +++
 rtl/datapath_counter.sv | 81 ++++++++
 tb/tb_datapath_counter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Definitions shared by the bit-counting controller and its datapath: count sizing
// and the strobe bit positions both sides agree on.
package counter_pkg;

    localparam int STB_W       = 4;
    localparam int STB_OUT_RST = 0;
    localparam int STB_ADD     = 1;
    localparam int STB_SFT     = 2;
    localparam int STB_DONE    = 3;

    typedef logic [STB_W-1:0] strobe_t;

    // Bits needed to hold the value `width` itself (an all-ones operand).
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

    // True when more than one strobe is active at once.
    function automatic logic strobe_conflict(input strobe_t s);
        return (s & (s - strobe_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/shift_reg_lsb.sv
// Operand register with parallel load and right shift, exposing |q and q[0].
// Latency: one edge for load/shift; outputs are combinational from q. No backpressure.
module shift_reg_lsb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             any,
    output logic             lsb
);

    logic [WIDTH-1:0] q;

    // Load wins over shift; the controller never asks for both in a legal cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign any = |q;
    assign lsb = q[0];

endmodule

// File: rtl/datapath_counter.sv
// Ones-counting datapath driven by the controller strobes; loads an operand over valid/ready.
// Latency: start one edge after accept, count one edge after done; din_ready only in idle with start low.
module datapath_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             start,
    input  logic             out_rst,
    input  logic             add,
    input  logic             sft,
    input  logic             done,
    output logic             z,
    output logic             a0,
    output logic [CW-1:0]    count,
    output logic             count_valid,
    output logic             err
);

    strobe_t       stb;
    logic          accept;
    logic          proto_err;
    logic [CW-1:0] c_q;

    always_comb begin
        stb              = '0;
        stb[STB_OUT_RST] = out_rst;
        stb[STB_ADD]     = add;
        stb[STB_SFT]     = sft;
        stb[STB_DONE]    = done;
    end

    // Holding ready low during start keeps a second operand out until the controller leaves idle.
    assign din_ready = out_rst && !start;
    assign accept    = din_valid && din_ready;
    assign proto_err = strobe_conflict(stb) || (add && !a0);

    shift_reg_lsb #(
        .WIDTH (WIDTH)
    ) u_a (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (sft),
        .d     (din),
        .any   (z),
        .lsb   (a0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q         <= '0;
            count       <= '0;
            start       <= 1'b0;
            count_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            start       <= accept;
            count_valid <= done;
            if (done) begin
                count <= c_q;
            end
            // Clear takes priority if a faulty controller pairs out_rst with add.
            if (out_rst) begin
                c_q <= '0;
            end else if (add) begin
                c_q <= c_q + CW'(1);
            end
            if (proto_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_datapath_counter.sv
// Bench for datapath_counter: a behavioural controller plus table, random and corner sequences.
module tb_datapath_counter;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             start;
    logic             out_rst;
    logic             add;
    logic             sft;
    logic             done;
    logic             z;
    logic             a0;
    logic [CW-1:0]    count;
    logic             count_valid;
    logic             err;

    logic ctrl_en;
    logic m_out_rst, m_add, m_sft, m_done;

    int n_cmp = 0;
    int n_bad = 0;

    datapath_counter #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .start       (start),
        .out_rst     (out_rst),
        .add         (add),
        .sft         (sft),
        .done        (done),
        .z           (z),
        .a0          (a0),
        .count       (count),
        .count_valid (count_valid),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the control FSM: CHECK1 -> [ADD] -> SHIFT -> CHECK2 per bit.
    typedef enum {C_IDLE, C_CHK1, C_ADD, C_SFT, C_CHK2, C_DONE} cst_t;
    cst_t cst;

    always @(posedge clk) begin
        if (rst || !ctrl_en) begin
            cst <= C_IDLE;
        end else begin
            case (cst)
                C_IDLE:  cst <= start ? C_CHK1 : C_IDLE;
                C_CHK1:  cst <= a0 ? C_ADD : C_SFT;
                C_ADD:   cst <= C_SFT;
                C_SFT:   cst <= C_CHK2;
                C_CHK2:  cst <= z ? C_CHK1 : C_DONE;
                default: cst <= C_IDLE;
            endcase
        end
    end

    assign out_rst = ctrl_en ? (cst == C_IDLE) : m_out_rst;
    assign add     = ctrl_en ? (cst == C_ADD)  : m_add;
    assign sft     = ctrl_en ? (cst == C_SFT)  : m_sft;
    assign done    = ctrl_en ? (cst == C_DONE) : m_done;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_cnt(input int d);
        int ones = 0;
        for (int b = 0; b < WIDTH; b++) ones += (d >> b) & 1;
        return ones;
    endfunction

    // Cycles from the start pulse to count_valid: 3 per visited bit, 1 per set bit, DONE + output.
    function automatic int model_lat(input int d);
        int iters = 1;
        for (int b = 0; b < WIDTH; b++) if (((d >> b) & 1) != 0) iters = b + 1;
        return 3 * iters + model_cnt(d) + 2;
    endfunction

    task automatic send(input logic [WIDTH-1:0] d, output bit ok);
        din       = d;
        din_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (din_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_result(output int cnt, output int lat, output int cnt_at_start,
                               output int start_w, output int acc_n, output bit ok);
        int s_cyc;
        s_cyc        = -1;
        cnt          = -1;
        lat          = -1;
        cnt_at_start = -1;
        start_w      = 0;
        acc_n        = 0;
        ok           = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (start) begin
                if (s_cyc < 0) begin
                    s_cyc        = i;
                    cnt_at_start = int'(count);
                end
                start_w++;
            end
            if (count_valid) begin
                cnt = int'(count);
                lat = i - s_cyc;
                ok  = (s_cyc >= 0);
                break;
            end
            if (din_valid && din_ready) acc_n++;
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] d, input int ec, input int el, input string tag);
        bit ok;
        int cnt, lat, cas, sw, an;
        send(d, ok);
        check({tag, "_accept"}, int'(ok), 1);
        if (!ok) return;
        wait_result(cnt, lat, cas, sw, an, ok);
        check({tag, "_result_seen"}, int'(ok), 1);
        if (!ok) return;
        check({tag, "_count"}, cnt, ec);
        check({tag, "_latency"}, lat, el);
        check({tag, "_start_width"}, sw, 1);
        check({tag, "_err"}, int'(err), 0);
        @(negedge clk);
        check({tag, "_cv_one_cycle"}, int'(count_valid), 0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] d;
        int               exp_cnt;
        int               exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit ok;
        int cnt, lat, cas, sw, an, cv_seen;
        logic [WIDTH-1:0] rd;

        vecs[0] = '{8'hB5, 5, 31};
        vecs[1] = '{8'h00, 0, 5};
        vecs[2] = '{8'hFF, 8, 34};
        vecs[3] = '{8'h01, 1, 6};
        vecs[4] = '{8'h80, 1, 27};
        vecs[5] = '{8'h03, 2, 10};

        rst = 1'b1; din = '0; din_valid = 1'b0; ctrl_en = 1'b1;
        m_out_rst = 1'b0; m_add = 1'b0; m_sft = 1'b0; m_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_start", int'(start), 0);
        check("rst_count", int'(count), 0);
        check("rst_count_valid", int'(count_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_z", int'(z), 0);
        check("rst_a0", int'(a0), 0);
        check("rst_din_ready", int'(din_ready), 1);

        for (int i = 0; i < 6; i++) run_op(vecs[i].d, vecs[i].exp_cnt, vecs[i].exp_lat, "table");

        // din_valid held high across two operands.
        din = 8'hB5; din_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (din_ready) begin ok = 1'b1; break; end
        end
        check("hold_first_accept", int'(ok), 1);
        @(posedge clk);
        #1 din = 8'h03;
        wait_result(cnt, lat, cas, sw, an, ok);
        check("hold_first_seen", int'(ok), 1);
        check("hold_first_count", cnt, 5);
        check("hold_no_extra_accept", an, 0);
        check("hold_start_width", sw, 1);
        check("hold_ready_back", int'(din_ready), 1);
        @(posedge clk);
        #1 din_valid = 1'b0;
        wait_result(cnt, lat, cas, sw, an, ok);
        check("hold_second_seen", int'(ok), 1);
        check("hold_count_held", cas, 5);
        check("hold_second_count", cnt, 2);
        check("hold_second_latency", lat, 10);

        // Reset in the middle of counting 0x0F.
        send(8'h0F, ok);
        check("midrst_accept", int'(ok), 1);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_count", int'(count), 0);
        check("midrst_cv", int'(count_valid), 0);
        check("midrst_start", int'(start), 0);
        check("midrst_z", int'(z), 0);
        check("midrst_a0", int'(a0), 0);
        check("midrst_din_ready", int'(din_ready), 1);
        cv_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (count_valid) cv_seen++;
        end
        check("midrst_no_cv", cv_seen, 0);
        run_op(8'h03, 2, 10, "post_rst");

        for (int i = 0; i < 20; i++) begin
            rd = WIDTH'($urandom_range(0, 255));
            run_op(rd, model_cnt(int'(rd)), model_lat(int'(rd)), "rand");
        end

        // Protocol error cases with strobes driven by hand.
        ctrl_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("err_clear_after_rst", int'(err), 0);
        m_add = 1'b1; m_sft = 1'b1;
        @(posedge clk);
        #1 m_add = 1'b0; m_sft = 1'b0;
        @(negedge clk);
        check("err_multi_strobe", int'(err), 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("err_sticky", int'(err), 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("err_rst_clears", int'(err), 0);
        m_out_rst = 1'b1; din = 8'h01; din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0; m_out_rst = 1'b0;
        @(negedge clk);
        check("err_load_a0", int'(a0), 1);
        check("err_load_start", int'(start), 1);
        m_add = 1'b1;
        @(posedge clk);
        #1 m_add = 1'b0;
        @(negedge clk);
        check("err_legal_add", int'(err), 0);
        m_sft = 1'b1;
        @(posedge clk);
        #1 m_sft = 1'b0;
        @(negedge clk);
        check("err_shift_a0", int'(a0), 0);
        check("err_shift_z", int'(z), 0);
        m_add = 1'b1;
        @(posedge clk);
        #1 m_add = 1'b0;
        @(negedge clk);
        check("err_add_a0_zero", int'(err), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
